// File: rtl/wb_rr_arbiter_if.sv
// Bus bundle for the N-master round-robin Wishbone arbiter.
//
// Carries the packed per-master request/response lines (m_*) and the single
// pipelined slave port (s_*). Master i owns slice [i*AW +: AW] of m_addr,
// [i*DW +: DW] of m_data and [i*DW/8 +: DW/8] of m_sel.
//
// Modports:
//   slave  - the arbiter's view: it receives master requests and slave
//            responses, and drives master responses and slave requests.
//   master - the environment's view (masters plus the slave device).
interface wb_rr_arbiter_if #(
  parameter int N  = 4,
  parameter int AW = 32,
  parameter int DW = 32
) ();
  logic [N-1:0]        m_cyc;
  logic [N-1:0]        m_stb;
  logic [N-1:0]        m_we;
  logic [N*AW-1:0]     m_addr;
  logic [N*DW-1:0]     m_data;
  logic [N*DW/8-1:0]   m_sel;
  logic [N-1:0]        m_ack;
  logic [N-1:0]        m_err;
  logic [N-1:0]        m_stall;

  logic                s_cyc;
  logic                s_stb;
  logic                s_we;
  logic [AW-1:0]       s_addr;
  logic [DW-1:0]       s_data;
  logic [DW/8-1:0]     s_sel;
  logic                s_ack;
  logic                s_err;
  logic                s_stall;

  modport slave (
    input  m_cyc, m_stb, m_we, m_addr, m_data, m_sel,
    input  s_ack, s_err, s_stall,
    output m_ack, m_err, m_stall,
    output s_cyc, s_stb, s_we, s_addr, s_data, s_sel
  );

  modport master (
    output m_cyc, m_stb, m_we, m_addr, m_data, m_sel,
    output s_ack, s_err, s_stall,
    input  m_ack, m_err, m_stall,
    input  s_cyc, s_stb, s_we, s_addr, s_data, s_sel
  );
endinterface

// File: rtl/wb_rr_arbiter.sv
// N-master round-robin arbiter in front of one pipelined Wishbone slave.
//
// The winner keeps the slave for its whole cyc. Accepted-but-unanswered
// requests are counted and capped at MAX_OUT; a watchdog aborts the owner
// with an err if the slave stays silent for TIMEOUT cycles.
//
// Ports:
//   CLK          clock, all state on the rising edge
//   RST          synchronous reset, active high
//   bus          wb_rr_arbiter_if.slave: m_* per-master lines, s_* slave port
//   grant        one-hot registered owner, zero while idle
//   timeout_evt  one-cycle pulse when the watchdog fires
module wb_rr_arbiter #(
  parameter int N                = 4,
  parameter int AW               = 32,
  parameter int DW               = 32,
  parameter int MAX_OUT          = 4,
  parameter int TIMEOUT          = 64,
  parameter int OPT_ZERO_ON_IDLE = 0
) (
  input  logic                 CLK,
  input  logic                 RST,
  wb_rr_arbiter_if.slave       bus,
  output logic [N-1:0]         grant,
  output logic                 timeout_evt
);

  localparam int LW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(MAX_OUT + 1);
  localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int SW = DW / 8;

  localparam logic [CW-1:0] MAX_C   = CW'(MAX_OUT);
  localparam logic [WW-1:0] WD_LAST = WW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_OWNED,
    ST_ABORT
  } state_t;

  state_t          state_q;
  logic [LW-1:0]   owner_q;
  logic [LW-1:0]   last_q;
  logic [N-1:0]    grant_q;
  logic [CW-1:0]   out_q;
  logic [CW-1:0]   out_d;
  logic [WW-1:0]   wd_q;
  logic [WW-1:0]   wd_d;

  logic            owned;
  logic            own_cyc;
  logic            own_stb;
  logic            out_full;
  logic            stb_w;
  logic            accept;
  logic            resp;
  logic            fire;
  logic            any_req;
  logic [LW-1:0]   win;

  logic [N-1:0]    ack_w;
  logic [N-1:0]    err_w;
  logic [N-1:0]    stall_w;
  logic [LW-1:0]   msel;
  logic            we_w;
  logic [AW-1:0]   addr_w;
  logic [DW-1:0]   data_w;
  logic [SW-1:0]   sel_w;

  assign owned    = (state_q == ST_OWNED);
  assign own_cyc  = bus.m_cyc[owner_q];
  assign own_stb  = bus.m_stb[owner_q];
  assign out_full = (out_q == MAX_C);
  assign stb_w    = owned && own_cyc && own_stb && !out_full;
  assign accept   = stb_w && !bus.s_stall;
  assign resp     = bus.s_ack || bus.s_err;
  // Fires on the TIMEOUT-th consecutive silent cycle with work outstanding.
  // Gated by own_cyc so a releasing owner goes straight back to IDLE.
  assign fire     = (TIMEOUT > 0) && owned && own_cyc && (out_q != '0) &&
                    !resp && (wd_q == WD_LAST);
  assign any_req  = |bus.m_cyc;

  // Round-robin pick: rotated distance from last_q, with last_q itself at
  // distance N so the previous owner always ranks lowest.
  always_comb begin : pick
    int unsigned best_d;
    int unsigned d;
    win    = '0;
    best_d = 32'(N) + 1;
    d      = 0;
    for (int unsigned i = 0; i < N; i++) begin
      d = (i > 32'(last_q)) ? (i - 32'(last_q)) : (i + 32'(N) - 32'(last_q));
      if (bus.m_cyc[i] && (d < best_d)) begin
        best_d = d;
        win    = LW'(i);
      end
    end
  end

  // Outstanding count: an ack with nothing outstanding is dropped, so the
  // counter can neither underflow nor be pulled below a fresh accept.
  always_comb begin
    out_d = out_q;
    if (accept && !(resp && (out_q != '0))) begin
      out_d = out_q + 1'b1;
    end else if (!accept && resp && (out_q != '0)) begin
      out_d = out_q - 1'b1;
    end
  end

  always_comb begin
    wd_d = wd_q + 1'b1;
    if ((out_q == '0) || resp) begin
      wd_d = '0;
    end
  end

  // Per-master responses; only the current owner sees anything.
  always_comb begin
    ack_w   = '0;
    err_w   = '0;
    stall_w = '1;
    if (owned) begin
      stall_w[owner_q] = bus.s_stall || out_full;
      ack_w[owner_q]   = bus.s_ack;
      err_w[owner_q]   = bus.s_err || fire;
    end
  end

  // Request path mux; master 0 is presented outside OWNED.
  always_comb begin
    msel   = owned ? owner_q : '0;
    we_w   = '0;
    addr_w = '0;
    data_w = '0;
    sel_w  = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (LW'(i) == msel) begin
        we_w   = bus.m_we[i];
        addr_w = bus.m_addr[i*AW +: AW];
        data_w = bus.m_data[i*DW +: DW];
        sel_w  = bus.m_sel[i*SW +: SW];
      end
    end
    if ((OPT_ZERO_ON_IDLE != 0) && !stb_w) begin
      we_w   = '0;
      addr_w = '0;
      data_w = '0;
      sel_w  = '0;
    end
  end

  assign bus.m_ack   = ack_w;
  assign bus.m_err   = err_w;
  assign bus.m_stall = stall_w;
  assign bus.s_cyc   = owned && own_cyc;
  assign bus.s_stb   = stb_w;
  assign bus.s_we    = we_w;
  assign bus.s_addr  = addr_w;
  assign bus.s_data  = data_w;
  assign bus.s_sel   = sel_w;
  assign grant       = grant_q;
  assign timeout_evt = fire;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      owner_q <= '0;
      last_q  <= LW'(N - 1);
      grant_q <= '0;
      out_q   <= '0;
      wd_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          out_q <= '0;
          wd_q  <= '0;
          if (any_req) begin
            state_q <= ST_OWNED;
            owner_q <= win;
            grant_q <= N'(1) << win;
          end
        end
        ST_OWNED: begin
          if (!own_cyc) begin
            state_q <= ST_IDLE;
            last_q  <= owner_q;
            grant_q <= '0;
            out_q   <= '0;
            wd_q    <= '0;
          end else if (fire) begin
            state_q <= ST_ABORT;
            out_q   <= '0;
            wd_q    <= '0;
          end else begin
            out_q <= out_d;
            wd_q  <= wd_d;
          end
        end
        ST_ABORT: begin
          if (!own_cyc) begin
            state_q <= ST_IDLE;
            last_q  <= owner_q;
            grant_q <= '0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          grant_q <= '0;
          out_q   <= '0;
          wd_q    <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
module tb_wb_rr_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic           CLK = 1'b0;
  logic           RST = 1'b1;
  logic [N-1:0]   grant;
  logic           tevt;

  always #5 CLK = ~CLK;

  wb_rr_arbiter_if #(.N(N), .AW(AW), .DW(DW)) bus ();

  wb_rr_arbiter #(
    .N(N), .AW(AW), .DW(DW), .MAX_OUT(4), .TIMEOUT(8), .OPT_ZERO_ON_IDLE(0)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus),
    .grant(grant),
    .timeout_evt(tevt)
  );

  // Expected vector: {grant[4], s_cyc, s_stb, m_ack[4], m_err[4], m_stall[4], timeout_evt}
  typedef struct {
    logic        rst;
    logic [3:0]  cyc;
    logic [3:0]  stb;
    logic        ack;
    logic        err;
    logic        stall;
    logic [18:0] exp;
    string       name;
  } vec_t;

  vec_t        tbl[$];
  logic [18:0] sb_q[$];
  logic [68:0] dp_q[$];
  logic [68:0] dp_ref[N];
  int          total = 0;
  int          bad   = 0;

  function automatic logic [18:0] ex(input logic [3:0] g, input logic c, input logic s,
                                     input logic [3:0] a, input logic [3:0] e,
                                     input logic [3:0] st, input logic t);
    return {g, c, s, a, e, st, t};
  endfunction

  function automatic void add(input logic rst, input logic [3:0] cyc, input logic [3:0] stb,
                              input logic ack, input logic err, input logic stall,
                              input logic [18:0] exp, input string name);
    vec_t v;
    v.rst = rst; v.cyc = cyc; v.stb = stb; v.ack = ack; v.err = err; v.stall = stall;
    v.exp = exp; v.name = name;
    tbl.push_back(v);
  endfunction

  task automatic step(input logic rst, input logic [3:0] cyc, input logic [3:0] stb,
                      input logic ack, input logic err, input logic stall,
                      input logic [18:0] exp, input string name);
    logic [18:0] got;
    logic [18:0] want;
    logic [68:0] dgot;
    logic [68:0] dwant;
    @(posedge CLK);
    #1;
    RST         = rst;
    bus.m_cyc   = cyc;
    bus.m_stb   = stb;
    bus.s_ack   = ack;
    bus.s_err   = err;
    bus.s_stall = stall;
    sb_q.push_back(exp);
    if (exp[13]) begin
      for (int i = 0; i < N; i++) if (exp[15+i]) dp_q.push_back(dp_ref[i]);
    end
    #4;
    got  = {grant, bus.s_cyc, bus.s_stb, bus.m_ack, bus.m_err, bus.m_stall, tevt};
    want = sb_q.pop_front();
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%b want=%b (grant,cyc,stb,ack,err,stall,tevt)", name, got, want);
    end
    if (dp_q.size() != 0) begin
      dgot  = {bus.s_we, bus.s_addr, bus.s_data, bus.s_sel};
      dwant = dp_q.pop_front();
      total++;
      if (dgot !== dwant) begin
        bad++;
        $display("FAIL %s_datapath: got=%h want=%h", name, dgot, dwant);
      end
    end
  endtask

  initial begin
    logic [18:0] idle_e;
    logic [3:0]  oh;

    for (int i = 0; i < N; i++) begin
      bus.m_we[i]               = i[0];
      bus.m_addr[i*AW +: AW]    = 32'hA000_0000 + 32'(i) * 32'h0000_0104;
      bus.m_data[i*DW +: DW]    = 32'hD0D0_0000 | 32'(i);
      bus.m_sel[i*4 +: 4]       = 4'b0001 << i;
      dp_ref[i] = {i[0], 32'hA000_0000 + 32'(i) * 32'h0000_0104,
                   32'hD0D0_0000 | 32'(i), 4'b0001 << i};
    end
    bus.m_cyc = '0; bus.m_stb = '0;
    bus.s_ack = 1'b0; bus.s_err = 1'b0; bus.s_stall = 1'b0;

    idle_e = ex(4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b1111, 1'b0);

    // Basic grant/release with two requesters.
    add(1, 4'b0000, 4'b0000, 0, 0, 0, idle_e, "reset");
    add(0, 4'b0101, 4'b0000, 0, 0, 0, idle_e, "arb_latency");
    add(0, 4'b0101, 4'b0001, 0, 0, 0, ex(4'b0001, 1, 1, 0, 0, 4'b1110, 0), "m0_stb");
    add(0, 4'b0101, 4'b0000, 1, 0, 0, ex(4'b0001, 1, 0, 4'b0001, 0, 4'b1110, 0), "m0_ack");
    add(0, 4'b0100, 4'b0000, 0, 0, 0, ex(4'b0001, 0, 0, 0, 0, 4'b1110, 0), "m0_release");
    add(0, 4'b0100, 4'b0000, 0, 0, 0, idle_e, "idle_gap");
    add(0, 4'b0100, 4'b0100, 0, 0, 0, ex(4'b0100, 1, 1, 0, 0, 4'b1011, 0), "m2_stb");
    add(0, 4'b0100, 4'b0000, 1, 0, 0, ex(4'b0100, 1, 0, 4'b0100, 0, 4'b1011, 0), "m2_ack");
    add(0, 4'b0000, 4'b0000, 0, 0, 0, ex(4'b0100, 0, 0, 0, 0, 4'b1011, 0), "m2_release");
    add(0, 4'b0000, 4'b0000, 0, 0, 0, idle_e, "idle");

    // All masters hold cyc; each releases for one cycle after one transfer.
    add(1, 4'b1111, 4'b0000, 0, 0, 0, idle_e, "reset2");
    for (int t = 0; t < 5; t++) begin
      oh = 4'b0001 << (t % 4);
      add(0, 4'b1111, 4'b0000, 0, 0, 0, idle_e, "rr_idle");
      add(0, 4'b1111, 4'b1111, 0, 0, 0, ex(oh, 1, 1, 0, 0, ~oh, 0), "rr_stb");
      add(0, 4'b1111, 4'b0000, 1, 0, 0, ex(oh, 1, 0, oh, 0, ~oh, 0), "rr_ack");
      add(0, 4'b1111 & ~oh, 4'b0000, 0, 0, 0, ex(oh, 0, 0, 0, 0, ~oh, 0), "rr_release");
    end

    // Outstanding cap, same-cycle accept+ack, late ack after release.
    add(0, 4'b0010, 4'b0000, 0, 0, 0, idle_e, "m1_req");
    for (int k = 0; k < 4; k++)
      add(0, 4'b0010, 4'b0010, 0, 0, 0, ex(4'b0010, 1, 1, 0, 0, 4'b1101, 0), "cap_accept");
    for (int k = 0; k < 2; k++)
      add(0, 4'b0010, 4'b0010, 0, 0, 0, ex(4'b0010, 1, 0, 0, 0, 4'b1111, 0), "cap_full");
    add(0, 4'b0010, 4'b0010, 1, 0, 0, ex(4'b0010, 1, 0, 4'b0010, 0, 4'b1111, 0), "cap_ack");
    add(0, 4'b0010, 4'b0010, 0, 0, 0, ex(4'b0010, 1, 1, 0, 0, 4'b1101, 0), "cap_fifth");
    add(0, 4'b0010, 4'b0010, 0, 0, 0, ex(4'b0010, 1, 0, 0, 0, 4'b1111, 0), "cap_full2");
    add(0, 4'b0010, 4'b0000, 1, 0, 0, ex(4'b0010, 1, 0, 4'b0010, 0, 4'b1111, 0), "drain4");
    add(0, 4'b0010, 4'b0000, 1, 0, 0, ex(4'b0010, 1, 0, 4'b0010, 0, 4'b1101, 0), "drain3");
    add(0, 4'b0010, 4'b0010, 1, 0, 0, ex(4'b0010, 1, 1, 4'b0010, 0, 4'b1101, 0), "same_cycle");
    add(0, 4'b0010, 4'b0010, 0, 0, 0, ex(4'b0010, 1, 1, 0, 0, 4'b1101, 0), "hold2_acc3");
    add(0, 4'b0010, 4'b0010, 0, 0, 0, ex(4'b0010, 1, 1, 0, 0, 4'b1101, 0), "hold2_acc4");
    add(0, 4'b0010, 4'b0010, 0, 0, 0, ex(4'b0010, 1, 0, 0, 0, 4'b1111, 0), "hold2_full");
    add(0, 4'b0010, 4'b0000, 1, 0, 0, ex(4'b0010, 1, 0, 4'b0010, 0, 4'b1111, 0), "to3");
    add(0, 4'b0010, 4'b0000, 1, 0, 0, ex(4'b0010, 1, 0, 4'b0010, 0, 4'b1101, 0), "to2");
    add(0, 4'b0000, 4'b0000, 0, 0, 0, ex(4'b0010, 0, 0, 0, 0, 4'b1101, 0), "drop_out2");
    add(0, 4'b0000, 4'b0000, 1, 0, 0, idle_e, "late_ack");
    add(0, 4'b0100, 4'b0000, 0, 0, 0, idle_e, "m2_req");
    for (int k = 0; k < 4; k++)
      add(0, 4'b0100, 4'b0100, 0, 0, 0, ex(4'b0100, 1, 1, 0, 0, 4'b1011, 0), "cnt_cleared");
    add(0, 4'b0100, 4'b0100, 0, 0, 0, ex(4'b0100, 1, 0, 0, 0, 4'b1111, 0), "cnt_full");
    add(0, 4'b0000, 4'b0000, 0, 0, 0, ex(4'b0100, 0, 0, 0, 0, 4'b1111, 0), "rel_full");
    add(0, 4'b0000, 4'b0000, 0, 0, 0, idle_e, "idle3");

    @(posedge CLK);
    @(posedge CLK);
    foreach (tbl[i])
      step(tbl[i].rst, tbl[i].cyc, tbl[i].stb, tbl[i].ack, tbl[i].err, tbl[i].stall,
           tbl[i].exp, tbl[i].name);

    // Watchdog: one accepted stb, slave never answers.
    step(0, 4'b0001, 4'b0000, 0, 0, 0, idle_e, "wd_req");
    step(0, 4'b0001, 4'b0001, 0, 0, 0, ex(4'b0001, 1, 1, 0, 0, 4'b1110, 0), "wd_stb");
    for (int i = 1; i < 8; i++)
      step(0, 4'b0001, 4'b0000, 0, 0, 0, ex(4'b0001, 1, 0, 0, 0, 4'b1110, 0), "wd_wait");
    step(0, 4'b0001, 4'b0000, 0, 0, 0, ex(4'b0001, 1, 0, 0, 4'b0001, 4'b1110, 1), "wd_fire");
    step(0, 4'b0001, 4'b0000, 1, 0, 0, ex(4'b0001, 0, 0, 0, 0, 4'b1111, 0), "abort_no_ack");
    step(0, 4'b0001, 4'b0001, 0, 0, 0, ex(4'b0001, 0, 0, 0, 0, 4'b1111, 0), "abort_hold");
    step(0, 4'b0000, 4'b0000, 0, 1, 0, ex(4'b0001, 0, 0, 0, 0, 4'b1111, 0), "abort_release");
    step(0, 4'b0000, 4'b0000, 0, 0, 0, idle_e, "abort_idle");

    // Reset while owned with three outstanding.
    step(0, 4'b1000, 4'b0000, 0, 0, 0, idle_e, "m3_req");
    for (int k = 0; k < 3; k++)
      step(0, 4'b1000, 4'b1000, 0, 0, 0, ex(4'b1000, 1, 1, 0, 0, 4'b0111, 0), "m3_stb");
    step(1, 4'b1000, 4'b0000, 0, 0, 0, ex(4'b1000, 1, 0, 0, 0, 4'b0111, 0), "rst_owned");
    step(0, 4'b1001, 4'b0000, 0, 0, 0, idle_e, "rst_after");
    step(0, 4'b1001, 4'b0000, 0, 0, 0, ex(4'b0001, 1, 0, 0, 0, 4'b1110, 0), "rst_m0_wins");
    for (int k = 0; k < 4; k++)
      step(0, 4'b1001, 4'b0001, 0, 0, 0, ex(4'b0001, 1, 1, 0, 0, 4'b1110, 0), "post_rst_acc");
    step(0, 4'b1001, 4'b0000, 0, 1, 1, ex(4'b0001, 1, 0, 0, 4'b0001, 4'b1111, 0), "err_fwd");
    step(0, 4'b1000, 4'b0000, 0, 0, 0, ex(4'b0001, 0, 0, 0, 0, 4'b1110, 0), "m0_drop");
    step(0, 4'b1000, 4'b0000, 0, 0, 0, idle_e, "final_idle");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
